// File: rtl/apb_arbiter_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_arbiter_master: two-requester round-robin APB master with a      |
// | bounded wait on pready. Revision: 1.0                                |
// +--------------------------------------------------------------------+
module apb_arbiter_master #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_done,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic w_grant;
  logic w_timeout;

  // The requester not granted last wins a tie; a lone request always wins.
  assign w_grant   = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  assign w_timeout = (TIMEOUT != 0) && !pready && (wcnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (|req_valid) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (pready || w_timeout) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    last_d    = last_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    wcnt_d    = '0;
    psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d = (state_d == S_ACCESS);
    done_d    = {(state_d == S_DONE) && last_q, (state_d == S_DONE) && !last_q};
    if (state_q == S_IDLE && |req_valid) begin
      last_d   = w_grant;
      pwrite_d = w_grant ? req_write[1] : req_write[0];
      paddr_d  = w_grant ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
      pwdata_d = w_grant ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
    end
    if (state_q == S_ACCESS) begin
      wcnt_d = wcnt_q + 1'b1;
      if (pready) begin
        rdata_d = pwrite_q ? '0 : prdata;
        err_d   = pslverr;
      end else if (w_timeout) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= 1'b1;
      wcnt_q    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      last_q    <= last_d;
      wcnt_q    <= wcnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign req_done  = done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_arbiter_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_apb_arbiter_master: directed bench with a four-register APB slave |
// | model. Revision: 1.0                                                 |
// +--------------------------------------------------------------------+
module tb_apb_arbiter_master;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      req_done;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata, prdata;
  logic            pready, pslverr;

  logic            slave_rst;
  logic            stuck;
  int              wait_n;
  int              wcnt;
  logic [7:0]      mem [0:3];

  int checks = 0;
  int failures = 0;

  logic [1:0]    trace [0:127];
  logic [DW-1:0] rd;
  logic          er, st, seen, any_done;
  int            lat, pn, en, g;
  int            gl [0:3];
  int            i0, i1;
  logic [1:0]    first_done;

  apb_arbiter_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // Slave: registers 0-3, error above 3, wait_n low cycles per access.
  assign pready  = !stuck && (wait_n == 0 || (penable && wcnt >= wait_n));
  assign pslverr = (paddr > 3);
  assign prdata  = (paddr < 4) ? mem[paddr[1:0]] : 8'h00;

  always @(posedge clk) begin
    if (slave_rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
      wcnt <= 0;
    end else if (psel && penable) begin
      if (pready) begin
        wcnt <= 0;
        if (pwrite && paddr < 4) mem[paddr[1:0]] <= pwdata;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[id]            = wr;
    req_addr[id*AW +: AW]    = a;
    req_wdata[id*DW +: DW]   = d;
  endtask

  // Called at a negedge with the DUT idle; c counts cycles after the request is sampled.
  task automatic do_req(input int id, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic [DW-1:0] rdata, output logic err, output int lt,
                        output int psel_n, output int pen_n, output logic stable);
    logic got;
    got = 1'b0; lt = 0; psel_n = 0; pen_n = 0; stable = 1'b1; rdata = '0; err = 1'b0;
    set_req(id, wr, a, d);
    req_valid[id] = 1'b1;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(negedge clk);
      trace[c] = {psel, penable};
      if (psel) begin
        psel_n++;
        if (paddr !== a || pwrite !== wr || pwdata !== d) stable = 1'b0;
      end
      if (penable) pen_n++;
      if (req_done != 2'b00) begin
        got = 1'b1; lt = c; rdata = rsp_rdata; err = rsp_err;
        check("done_vector", {30'd0, req_done}, 32'd1 << id);
      end
    end
    req_valid[id] = 1'b0;
    check("done_seen", {31'd0, got}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; slave_rst = 1'b1; stuck = 1'b0; wait_n = 0;
    req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {7'd0, psel, penable, pwrite, paddr, pwdata, req_done, rsp_rdata, rsp_err}, 32'd0);
    rst = 1'b0; slave_rst = 1'b0;
    @(negedge clk);

    // Zero-wait write then read back.
    do_req(0, 1'b1, 3'd0, 8'hDE, rd, er, lat, pn, en, st);
    check("wr_cyc1_setup", {30'd0, trace[1]}, 32'd2);
    check("wr_cyc2_access", {30'd0, trace[2]}, 32'd3);
    check("wr_done_cycle", lat, 3);
    check("wr_cyc3_idle_bus", {30'd0, trace[3]}, 32'd0);
    check("wr_rsp_rdata", {24'd0, rd}, 32'h00);
    do_req(0, 1'b0, 3'd0, 8'h00, rd, er, lat, pn, en, st);
    check("rd_rdata", {24'd0, rd}, 32'hDE);
    check("rd_err", {31'd0, er}, 32'd0);

    // Three wait states on a req1 write.
    wait_n = 3;
    do_req(1, 1'b1, 3'd2, 8'h5A, rd, er, lat, pn, en, st);
    check("ws_penable_cycles", en, 4);
    check("ws_psel_cycles", pn, 5);
    check("ws_bus_stable", {31'd0, st}, 32'd1);
    check("ws_done_cycle", lat, 6);
    wait_n = 0;

    // Round-robin with both requesters held valid.
    i0 = 0; i1 = 0; g = 0;
    set_req(0, 1'b1, 3'd0, 8'hDE);
    set_req(1, 1'b1, 3'd2, 8'hBE);
    req_valid = 2'b11;
    for (int c = 0; c < 200 && (i0 < 2 || i1 < 2); c++) begin
      @(negedge clk);
      if (req_done[0] && g < 4) begin
        gl[g] = 0; g++; i0++;
        if (i0 < 2) set_req(0, 1'b1, 3'd1, 8'hAD); else req_valid[0] = 1'b0;
      end
      if (req_done[1] && g < 4) begin
        gl[g] = 1; g++; i1++;
        if (i1 < 2) set_req(1, 1'b1, 3'd3, 8'hEF); else req_valid[1] = 1'b0;
      end
    end
    req_valid = 2'b00;
    @(negedge clk);
    check("rr_grant_count", g, 4);
    check("rr_grant0", gl[0], 0);
    check("rr_grant1", gl[1], 1);
    check("rr_grant2", gl[2], 0);
    check("rr_grant3", gl[3], 1);
    do_req(1, 1'b0, 3'd0, 8'h00, rd, er, lat, pn, en, st);
    check("rr_rd0", {24'd0, rd}, 32'hDE);
    do_req(0, 1'b0, 3'd1, 8'h00, rd, er, lat, pn, en, st);
    check("rr_rd1", {24'd0, rd}, 32'hAD);
    do_req(1, 1'b0, 3'd2, 8'h00, rd, er, lat, pn, en, st);
    check("rr_rd2", {24'd0, rd}, 32'hBE);
    do_req(0, 1'b0, 3'd3, 8'h00, rd, er, lat, pn, en, st);
    check("rr_rd3", {24'd0, rd}, 32'hEF);

    // Slave error on an unmapped address.
    do_req(0, 1'b0, 3'd5, 8'h00, rd, er, lat, pn, en, st);
    check("slverr_err", {31'd0, er}, 32'd1);
    check("slverr_rdata", {24'd0, rd}, 32'h00);

    // Stuck slave: timeout with non-zero prdata on the bus.
    stuck = 1'b1;
    do_req(1, 1'b0, 3'd0, 8'h00, rd, er, lat, pn, en, st);
    check("to_psel_cycles", pn, TO + 1);
    check("to_done_cycle", lat, TO + 2);
    check("to_err", {31'd0, er}, 32'd1);
    check("to_rdata", {24'd0, rd}, 32'h00);

    // Reset during ACCESS of a req0 transfer.
    set_req(0, 1'b0, 3'd1, 8'h00);
    req_valid[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (penable) seen = 1'b1;
    end
    check("rst_reached_access", {31'd0, seen}, 32'd1);
    rst = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    check("rst_outputs_zero", {7'd0, psel, penable, pwrite, paddr, pwdata, req_done, rsp_rdata, rsp_err}, 32'd0);
    rst = 1'b0; stuck = 1'b0;
    any_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (req_done != 2'b00) any_done = 1'b1;
    end
    check("rst_no_done", {31'd0, any_done}, 32'd0);

    set_req(0, 1'b0, 3'd0, 8'h00);
    set_req(1, 1'b0, 3'd1, 8'h00);
    req_valid = 2'b11;
    first_done = 2'b00;
    for (int c = 0; c < 40 && req_valid != 2'b00; c++) begin
      @(negedge clk);
      if (req_done != 2'b00 && first_done == 2'b00) begin
        first_done = req_done;
        if (req_done[0]) check("post_rst_rdata", {24'd0, rsp_rdata}, 32'hDE);
      end
      if (req_done[0]) req_valid[0] = 1'b0;
      if (req_done[1]) req_valid[1] = 1'b0;
    end
    check("post_rst_first_grant", {30'd0, first_done}, 32'd1);
    check("post_rst_both_served", {30'd0, req_valid}, 32'd0);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
